// File: rtl/btn_press_counter.sv
// Debounced push-button press counter.
// A raw active-low button is synchronized, debounced by a four-state FSM, and
// each confirmed press advances a 4-bit wrapping count shown on the LEDs.
`timescale 1ns/1ps
module btn_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       inc_btn,
  output logic [3:0] led,
  output logic       pressed
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  logic             sync_a;
  logic             btn_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       led_q, led_d;
  logic             pressed_q, pressed_d;
  logic             inc;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync_a <= 1'b1;
      btn_s  <= 1'b1;
    end else begin
      sync_a <= inc_btn;
      btn_s  <= sync_a;
    end
  end

  // Debounce FSM next state, counter and press strobe.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          inc     = 1'b1;
        end else begin
          state_d = PRESS_WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = PRESSED;
        end
      end
      REL_WAIT: begin
        if (!btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          state_d = REL_WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      // Any unexpected encoding falls back to IDLE with a cleared counter.
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the next state so they change on the transition edge.
  always_comb begin
    led_d     = inc ? led_q + 4'd1 : led_q;
    pressed_d = (state_d == PRESSED) || (state_d == REL_WAIT);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      led_q     <= 4'h0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      pressed_q <= pressed_d;
    end
  end

  assign led     = led_q;
  assign pressed = pressed_q;

endmodule

// File: doc/btn_press_counter.md
BTN_PRESS_COUNTER -- requirements
Module: btn_press_counter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 120000, consecutive synchronized samples that confirm a level change (10 ms at 12 MHz); legal range 2..2^20.
REQ-002 Port: clk  input  1  system clock, 12 MHz oscillator, all state on rising edge.
REQ-003 Port: rst_btn  input  1  reset button; reset is asynchronous and active-low; the block is in reset while rst_btn=0.
REQ-004 Port: inc_btn  input  1  increment push-button, raw and asynchronous; active-low (0 = pressed).
REQ-005 Port: led  output  4  registered press count, unsigned.
REQ-006 Port: pressed  output  1  registered debounced button level; 1 while state is PRESSED or REL_WAIT.

Function
REQ-007 inc_btn SHALL pass through a 2-flop synchronizer; the second-flop output is btn_s; nothing else samples inc_btn.
REQ-008 Debounce counter cnt SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and unsigned; it never exceeds DEBOUNCE_CYCLES-1.
REQ-009 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and REL_WAIT.
REQ-010 IDLE: btn_s=0 -> PRESS_WAIT with cnt=1; otherwise stay with cnt=0.
REQ-011 PRESS_WAIT, btn_s=1: -> IDLE with cnt=0; there is no increment.
REQ-012 PRESS_WAIT, btn_s=0 and cnt=DEBOUNCE_CYCLES-1: -> PRESSED, cnt=0, and led<=led+1 on the same edge.
REQ-013 PRESS_WAIT, btn_s=0 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
REQ-014 PRESSED: btn_s=1 -> REL_WAIT with cnt=1; otherwise stay with cnt=0.
REQ-015 REL_WAIT: btn_s=0 -> PRESSED with cnt=0.
REQ-016 REL_WAIT, btn_s=1 and cnt=DEBOUNCE_CYCLES-1: -> IDLE with cnt=0.
REQ-017 REL_WAIT, btn_s=1 otherwise: cnt<=cnt+1.
REQ-018 led SHALL change only on the REQ-012 transition, by exactly +1 per confirmed press; release never changes led.
REQ-019 Latency: inc_btn first sampled low at edge 0 and held low -> led increments at edge DEBOUNCE_CYCLES+1 (2 synchronizer edges plus DEBOUNCE_CYCLES FSM samples).
REQ-020 Wrap-around: led=4'hF plus a confirmed press -> 4'h0; no saturation, no carry output.
REQ-021 Bounce: any low pulse shorter than DEBOUNCE_CYCLES samples of btn_s SHALL NOT change led.
REQ-022 Bounce: any high glitch shorter than DEBOUNCE_CYCLES samples while pressed SHALL NOT return to IDLE.
REQ-023 Hold: holding the button indefinitely SHALL yield exactly one increment; there is no auto-repeat.
REQ-024 pressed SHALL be registered and update on the same edge as the state change: 1 from the REQ-012 edge until the REQ-016 edge.
REQ-025 Illegal or unused state encodings SHALL recover to IDLE on the next edge with cnt=0.

Reset
REQ-026 rst_btn=0 SHALL immediately, without waiting for clk, force led=4'h0, pressed=0, state=IDLE, cnt=0, and both synchronizer flops=1 (released).
REQ-027 Reset release SHALL be synchronous-safe: the first active edge after rst_btn rises behaves as IDLE with btn_s=1.
REQ-028 Reset mid-press SHALL abandon any partial debounce; a button held through reset release counts as one new press after the REQ-019 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset with led=4'hA, asserted asynchronously mid-cycle -> led=0 and pressed=0 before the next clk edge.
REQ-030 Clean press: inc_btn low from edge 0 and held -> led 0->1 and pressed=1 at edge 5, with no further change while held.
REQ-031 Bounce: inc_btn low for 3 cycles, high for 1, then low for 3, then high -> led stays 0 and pressed stays 0.
REQ-032 Release glitch while PRESSED: 2-cycle high pulse, then low -> pressed stays 1; a later clean press-release cycle makes led=2 total.
REQ-033 Wrap: 16 clean press/release cycles from reset -> led returns to 4'h0, with each intermediate value seen exactly once.
REQ-034 Reset asserted in PRESS_WAIT with cnt=2, button held, reset released -> led=1 exactly 5 edges after the first edge following release.
